// File: rtl/usb_word_assembler_if.sv
// Byte-stream and word-handshake bundle between the USB byte receiver,
// the word assembler and the stock-data consumer.
interface usb_word_assembler_if;
    logic        new_byte;
    logic [7:0]  data_in;
    logic        data_ack;
    logic [31:0] stock_data;
    logic        data_ready;
    logic        overrun;
    logic        frame_error;

    modport master (
        output new_byte, data_in, data_ack,
        input  stock_data, data_ready, overrun, frame_error
    );

    modport slave (
        input  new_byte, data_in, data_ack,
        output stock_data, data_ready, overrun, frame_error
    );
endinterface

// File: rtl/usb_word_assembler.sv
// Packs four received USB bytes (MSB first) into a 32-bit word held under a
// ready/ack handshake; discards stalled partial words and flags overruns.
module usb_word_assembler #(
    parameter int unsigned TIMEOUT_CYCLES = 1000
) (
    input logic                  clk,
    input logic                  n_rst,
    usb_word_assembler_if.slave  bus
);
    localparam int unsigned IDLE_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic {IDLE, COLLECT} state_t;

    state_t            state_q, state_d;
    logic [1:0]        byte_cnt_q, byte_cnt_d;
    logic [23:0]       hold_q, hold_d;
    logic [IDLE_W-1:0] idle_cnt_q, idle_cnt_d;
    logic [31:0]       stock_q, stock_d;
    logic              ready_q, ready_d;
    logic              overrun_q, overrun_d;
    logic              frame_error_q, frame_error_d;
    logic              word_load;

    // State and output registers
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q       <= IDLE;
            byte_cnt_q    <= 2'd0;
            hold_q        <= 24'd0;
            idle_cnt_q    <= '0;
            stock_q       <= 32'd0;
            ready_q       <= 1'b0;
            overrun_q     <= 1'b0;
            frame_error_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            byte_cnt_q    <= byte_cnt_d;
            hold_q        <= hold_d;
            idle_cnt_q    <= idle_cnt_d;
            stock_q       <= stock_d;
            ready_q       <= ready_d;
            overrun_q     <= overrun_d;
            frame_error_q <= frame_error_d;
        end
    end

    // Next-state, byte packing, timeout and handshake logic
    always_comb begin
        state_d       = state_q;
        byte_cnt_d    = byte_cnt_q;
        hold_d        = hold_q;
        idle_cnt_d    = idle_cnt_q;
        stock_d       = stock_q;
        ready_d       = ready_q;
        overrun_d     = 1'b0;
        frame_error_d = 1'b0;
        word_load     = 1'b0;

        case (state_q)
            IDLE: begin
                idle_cnt_d = '0;
                if (bus.new_byte) begin
                    hold_d     = {16'd0, bus.data_in};
                    byte_cnt_d = 2'd1;
                    state_d    = COLLECT;
                end
            end
            COLLECT: begin
                if (bus.new_byte) begin
                    idle_cnt_d = '0;
                    if (byte_cnt_q == 2'd3) begin
                        byte_cnt_d = 2'd0;
                        state_d    = IDLE;
                        // An ack on the completion edge frees the output slot
                        if (!ready_q || bus.data_ack) begin
                            stock_d   = {hold_q, bus.data_in};
                            word_load = 1'b1;
                        end else begin
                            overrun_d = 1'b1;
                        end
                    end else begin
                        hold_d     = {hold_q[15:0], bus.data_in};
                        byte_cnt_d = byte_cnt_q + 2'd1;
                    end
                end else if (idle_cnt_q == IDLE_LAST) begin
                    byte_cnt_d    = 2'd0;
                    idle_cnt_d    = '0;
                    state_d       = IDLE;
                    frame_error_d = 1'b1;
                end else begin
                    idle_cnt_d = idle_cnt_q + IDLE_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        if (word_load) begin
            ready_d = 1'b1;
        end else if (bus.data_ack) begin
            ready_d = 1'b0;
        end
    end

    assign bus.stock_data  = stock_q;
    assign bus.data_ready  = ready_q;
    assign bus.overrun     = overrun_q;
    assign bus.frame_error = frame_error_q;
endmodule

// File: tb/tb_usb_word_assembler.sv
// Directed and randomized check of usb_word_assembler against a queue-based
// byte/word reference model.
module tb_usb_word_assembler;
    localparam int unsigned TO = 8;

    logic clk = 1'b0;
    logic n_rst;
    always #5 clk = ~clk;

    usb_word_assembler_if bus ();

    usb_word_assembler #(.TIMEOUT_CYCLES(TO)) dut (
        .clk   (clk),
        .n_rst (n_rst),
        .bus   (bus.slave)
    );

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model: pending bytes of the current word, stall length, outputs
    logic [7:0]  mq[$];
    int unsigned gap;
    logic        m_ready;
    logic [31:0] m_word;
    logic        m_ovr;
    logic        m_fe;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".stock_data"},  bus.stock_data,         m_word);
        check({tag, ".data_ready"},  32'(bus.data_ready),    32'(m_ready));
        check({tag, ".overrun"},     32'(bus.overrun),       32'(m_ovr));
        check({tag, ".frame_error"}, 32'(bus.frame_error),   32'(m_fe));
    endtask

    task automatic model_reset();
        mq.delete();
        gap     = 0;
        m_ready = 1'b0;
        m_word  = 32'd0;
        m_ovr   = 1'b0;
        m_fe    = 1'b0;
    endtask

    task automatic model_step(input logic nb, input logic [7:0] d, input logic ack);
        logic loaded;
        loaded = 1'b0;
        m_ovr  = 1'b0;
        m_fe   = 1'b0;
        if (nb) begin
            mq.push_back(d);
            gap = 0;
            if (mq.size() == 4) begin
                logic [31:0] w;
                w = {mq[0], mq[1], mq[2], mq[3]};
                mq.delete();
                if (!m_ready || ack) begin
                    m_word  = w;
                    m_ready = 1'b1;
                    loaded  = 1'b1;
                end else begin
                    m_ovr = 1'b1;
                end
            end
        end else if (mq.size() != 0) begin
            gap++;
            if (gap == TO) begin
                mq.delete();
                gap  = 0;
                m_fe = 1'b1;
            end
        end
        if (ack && !loaded) m_ready = 1'b0;
    endtask

    // One clock: drive at negedge, advance, compare on the following negedge
    task automatic cycle(input string tag, input logic nb, input logic [7:0] d, input logic ack);
        bus.new_byte = nb;
        bus.data_in  = d;
        bus.data_ack = ack;
        model_step(nb, d, ack);
        @(posedge clk);
        @(negedge clk);
        check_all(tag);
    endtask

    task automatic send_word(input string tag, input logic [31:0] w, input logic ack_last);
        cycle(tag, 1'b1, w[31:24], 1'b0);
        cycle(tag, 1'b1, w[23:16], 1'b0);
        cycle(tag, 1'b1, w[15:8],  1'b0);
        cycle(tag, 1'b1, w[7:0],   ack_last);
    endtask

    initial begin
        logic [31:0] w;
        logic        ack;

        bus.new_byte = 1'b0;
        bus.data_in  = 8'd0;
        bus.data_ack = 1'b0;
        n_rst        = 1'b0;
        model_reset();
        #12;
        check_all("reset");
        @(negedge clk);
        n_rst = 1'b1;

        // Basic assembly and ack
        send_word("deadbeef", 32'hDEADBEEF, 1'b0);
        check("deadbeef.word", bus.stock_data, 32'hDEADBEEF);
        check("deadbeef.ready", 32'(bus.data_ready), 32'd1);
        cycle("deadbeef_ack", 1'b0, 8'd0, 1'b1);
        check("ack.ready_low", 32'(bus.data_ready), 32'd0);
        check("ack.word_kept", bus.stock_data, 32'hDEADBEEF);
        cycle("idle", 1'b0, 8'd0, 1'b1);

        // Overrun, then ack coinciding with completion
        send_word("w1", 32'h01020304, 1'b0);
        send_word("w2_ovr", 32'h05060708, 1'b0);
        check("ovr.pulse", 32'(bus.overrun), 32'd1);
        check("ovr.word_kept", bus.stock_data, 32'h01020304);
        cycle("ovr_end", 1'b0, 8'd0, 1'b0);
        check("ovr.single", 32'(bus.overrun), 32'd0);
        send_word("w2_ack", 32'h05060708, 1'b1);
        check("ackload.word", bus.stock_data, 32'h05060708);
        check("ackload.ready", 32'(bus.data_ready), 32'd1);
        check("ackload.no_ovr", 32'(bus.overrun), 32'd0);
        cycle("ackload_clr", 1'b0, 8'd0, 1'b1);

        // Timeout discard and realignment
        cycle("to_b0", 1'b1, 8'hAA, 1'b0);
        cycle("to_b1", 1'b1, 8'hBB, 1'b0);
        for (int i = 0; i < int'(TO); i++) cycle("to_gap", 1'b0, 8'd0, 1'b0);
        check("timeout.fe", 32'(bus.frame_error), 32'd1);
        check("timeout.ready", 32'(bus.data_ready), 32'd0);
        send_word("after_to", 32'h11223344, 1'b0);
        check("after_to.word", bus.stock_data, 32'h11223344);
        cycle("after_to_ack", 1'b0, 8'd0, 1'b1);

        // Byte in the final cycle of the window beats the timeout
        cycle("edge_b0", 1'b1, 8'h55, 1'b0);
        for (int i = 0; i < int'(TO) - 1; i++) cycle("edge_gap", 1'b0, 8'd0, 1'b0);
        cycle("edge_b1", 1'b1, 8'h66, 1'b0);
        check("edge.no_fe", 32'(bus.frame_error), 32'd0);
        for (int i = 0; i < int'(TO) - 1; i++) cycle("edge_gap2", 1'b0, 8'd0, 1'b0);
        cycle("edge_b2", 1'b1, 8'h77, 1'b0);
        cycle("edge_b3", 1'b1, 8'h88, 1'b0);
        check("edge.word", bus.stock_data, 32'h55667788);

        // Asynchronous reset mid-word with an unacked word present
        cycle("pre_rst_b0", 1'b1, 8'hCA, 1'b0);
        cycle("pre_rst_b1", 1'b1, 8'hFE, 1'b0);
        bus.new_byte = 1'b0;
        #2;
        n_rst = 1'b0;
        #1;
        model_reset();
        check("arst.word", bus.stock_data, 32'd0);
        check("arst.ready", 32'(bus.data_ready), 32'd0);
        check_all("arst");
        @(negedge clk);
        n_rst = 1'b1;
        send_word("cafef00d", 32'hCAFEF00D, 1'b0);
        check("cafef00d.word", bus.stock_data, 32'hCAFEF00D);
        cycle("cafef00d_ack", 1'b0, 8'd0, 1'b1);

        // 16 back-to-back words, each acked in its ready cycle
        for (int k = 0; k < 16; k++) begin
            w = $urandom;
            for (int b = 3; b >= 0; b--) begin
                ack = m_ready;
                w   = w;
                cycle("stream", 1'b1, w[8*b +: 8], ack);
            end
            check("stream.word", bus.stock_data, w);
            check("stream.no_ovr", 32'(bus.overrun), 32'd0);
        end
        cycle("stream_ack", 1'b0, 8'd0, 1'b1);

        // Randomized traffic with occasional long stalls
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 40) == 0) begin
                int len;
                len = int'($urandom_range(TO - 2, TO + 3));
                for (int g = 0; g < len; g++)
                    cycle("rnd_stall", 1'b0, 8'd0, 1'($urandom_range(0, 3) == 0));
            end else begin
                cycle("rnd", 1'($urandom_range(0, 3) != 0), 8'($urandom),
                      1'($urandom_range(0, 2) == 0));
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
